// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous-read RAM port between a clock-enable-gated CPU and a host port.
// Optional build macro MEM_ARB_HALT_BYPASS_EN: a halted CPU lets the host skip the MIN_CPU and MAX_BURST limits.
module mem_arbiter #(
  parameter int AW        = 16,
  parameter int DW        = 16,
  parameter int MAX_BURST = 16,
  parameter int MIN_CPU   = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [AW-1:0] i_cpu_read_addr,
  input  logic [AW-1:0] i_cpu_write_addr,
  input  logic [DW-1:0] i_cpu_write_data,
  input  logic          i_cpu_we,
  input  logic          i_cpu_halted,
  output logic          o_cpu_ce,
  output logic [DW-1:0] o_cpu_read_data,
  input  logic          i_host_req,
  input  logic          i_host_we,
  input  logic [AW-1:0] i_host_addr,
  input  logic [DW-1:0] i_host_wdata,
  output logic          o_host_gnt,
  output logic          o_host_rvalid,
  output logic [DW-1:0] o_host_rdata,
  output logic [AW-1:0] o_mem_read_addr,
  output logic [AW-1:0] o_mem_write_addr,
  output logic [DW-1:0] o_mem_write_data,
  output logic          o_mem_we,
  input  logic [DW-1:0] i_mem_read_data
);

  localparam int CW = $clog2(MIN_CPU + 1);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CPU_SAT    = CW'(MIN_CPU);
  localparam logic [CW-1:0] CPU_LAST   = CW'(MIN_CPU - 1);
  localparam logic [BW-1:0] BURST_SAT  = BW'(MAX_BURST);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  typedef enum logic [1:0] {S_CPU, S_HOST, S_RESUME} state_t;

  state_t          state_reg;
  logic [CW-1:0]   cpu_cnt_reg;
  logic [BW-1:0]   burst_cnt_reg;
  logic            host_rvalid_reg;
  logic            halt_bypass;

`ifdef MEM_ARB_HALT_BYPASS_EN
  assign halt_bypass = i_cpu_halted;
`else
  assign halt_bypass = 1'b0 & i_cpu_halted;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg       <= S_RESUME;
      cpu_cnt_reg     <= '0;
      burst_cnt_reg   <= '0;
      host_rvalid_reg <= 1'b0;
    end else begin
      host_rvalid_reg <= o_host_gnt & ~i_host_we;
      case (state_reg)
        S_CPU: begin
          if (cpu_cnt_reg != CPU_SAT) cpu_cnt_reg <= cpu_cnt_reg + CW'(1);
          if (i_host_req && ((cpu_cnt_reg >= CPU_LAST) || halt_bypass)) begin
            state_reg     <= S_HOST;
            burst_cnt_reg <= '0;
          end
        end
        S_HOST: begin
          if (!i_host_req) begin
            state_reg <= S_RESUME;
          end else begin
            if (burst_cnt_reg != BURST_SAT) burst_cnt_reg <= burst_cnt_reg + BW'(1);
            // ">=" so that a burst which outgrew the limit under bypass ends as soon as bypass drops
            if (!halt_bypass && (burst_cnt_reg >= BURST_LAST)) state_reg <= S_RESUME;
          end
        end
        default: begin
          state_reg   <= S_CPU;
          cpu_cnt_reg <= '0;
        end
      endcase
    end
  end

  // Resume cycle re-presents the frozen CPU read address so its pending read data is refetched.
  always_comb begin
    o_cpu_ce         = 1'b0;
    o_host_gnt       = 1'b0;
    o_mem_we         = 1'b0;
    o_mem_read_addr  = i_cpu_read_addr;
    o_mem_write_addr = i_cpu_write_addr;
    o_mem_write_data = i_cpu_write_data;
    case (state_reg)
      S_CPU: begin
        o_cpu_ce = 1'b1;
        o_mem_we = i_cpu_we;
      end
      S_HOST: begin
        o_host_gnt       = i_host_req;
        o_mem_we         = i_host_req & i_host_we;
        o_mem_read_addr  = i_host_addr;
        o_mem_write_addr = i_host_addr;
        o_mem_write_data = i_host_wdata;
      end
      default: ;
    endcase
  end

  assign o_cpu_read_data = i_mem_read_data;
  assign o_host_rdata    = i_mem_read_data;
  assign o_host_rvalid   = host_rvalid_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: fixed vector table, directed corner sequences and
// randomized traffic against a cycle-level ownership model with a shadow memory.
module tb_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int MAX_BURST = 16;
  localparam int MIN_CPU = 8;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b1;
  logic [AW-1:0] i_cpu_read_addr = '0, i_cpu_write_addr = '0, i_host_addr = '0;
  logic [DW-1:0] i_cpu_write_data = '0, i_host_wdata = '0;
  logic i_cpu_we = 1'b0, i_cpu_halted = 1'b0, i_host_req = 1'b0, i_host_we = 1'b0;
  logic o_cpu_ce, o_host_gnt, o_host_rvalid, o_mem_we;
  logic [DW-1:0] o_cpu_read_data, o_host_rdata, o_mem_write_data, i_mem_read_data;
  logic [AW-1:0] o_mem_read_addr, o_mem_write_addr;

  always #5 i_clk = ~i_clk;

  mem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST), .MIN_CPU(MIN_CPU)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_cpu_read_addr(i_cpu_read_addr), .i_cpu_write_addr(i_cpu_write_addr),
    .i_cpu_write_data(i_cpu_write_data), .i_cpu_we(i_cpu_we), .i_cpu_halted(i_cpu_halted),
    .o_cpu_ce(o_cpu_ce), .o_cpu_read_data(o_cpu_read_data),
    .i_host_req(i_host_req), .i_host_we(i_host_we), .i_host_addr(i_host_addr),
    .i_host_wdata(i_host_wdata), .o_host_gnt(o_host_gnt), .o_host_rvalid(o_host_rvalid),
    .o_host_rdata(o_host_rdata), .o_mem_read_addr(o_mem_read_addr),
    .o_mem_write_addr(o_mem_write_addr), .o_mem_write_data(o_mem_write_data),
    .o_mem_we(o_mem_we), .i_mem_read_data(i_mem_read_data)
  );

  // RAM environment: registered read, read-before-write
  bit [15:0] ram [65536];
  always @(posedge i_clk) begin
    i_mem_read_data <= ram[o_mem_read_addr];
    if (o_mem_we) ram[o_mem_write_addr] <= o_mem_write_data;
  end

  int wr_total = 0;
  int wr_40 = 0;
  always @(posedge i_clk) begin
    if (o_mem_we) begin
      wr_total <= wr_total + 1;
      if (o_mem_write_addr == 16'h0040) wr_40 <= wr_40 + 1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Reference model: who owns memory, how long the CPU has run, how many grants were lent
  typedef enum int {M_RUN, M_LEND, M_RETURN} owner_t;
  owner_t m_owner;
  int m_run, m_lent;
  bit [15:0] shadow [65536];
  bit m_rvalid, m_rd_known;
  logic [15:0] m_rd;
  logic obs_gnt, obs_ce;

  function automatic bit halt_skips_limits();
`ifdef MEM_ARB_HALT_BYPASS_EN
    return i_cpu_halted;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_owner = M_RETURN;
    m_run = 0;
    m_lent = 0;
    m_rvalid = 1'b0;
    m_rd_known = 1'b0;
  endtask

  task automatic apply_reset();
    i_rst_n = 1'b0;
    #1;
    chk1("rst.ce", o_cpu_ce, 1'b0);
    chk1("rst.gnt", o_host_gnt, 1'b0);
    chk1("rst.we", o_mem_we, 1'b0);
    chk1("rst.rvalid", o_host_rvalid, 1'b0);
    model_reset();
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
  endtask

  // Called 1 time unit after a rising edge with inputs already driven; returns at the same phase.
  task automatic cycle_check(input string tag);
    logic e_ce, e_gnt, e_we;
    logic [15:0] e_ra, e_wa, e_wd;
    bit skip;
    #4;
    skip  = halt_skips_limits();
    e_ce  = (m_owner == M_RUN);
    e_gnt = (m_owner == M_LEND) && i_host_req;
    e_we  = (m_owner == M_RUN) ? i_cpu_we : (e_gnt && i_host_we);
    e_ra  = (m_owner == M_LEND) ? i_host_addr : i_cpu_read_addr;
    e_wa  = (m_owner == M_LEND) ? i_host_addr : i_cpu_write_addr;
    e_wd  = (m_owner == M_LEND) ? i_host_wdata : i_cpu_write_data;
    chk1({tag, ".ce"}, o_cpu_ce, e_ce);
    chk1({tag, ".gnt"}, o_host_gnt, e_gnt);
    chk1({tag, ".we"}, o_mem_we, e_we);
    chk16({tag, ".raddr"}, o_mem_read_addr, e_ra);
    if (e_we) begin
      chk16({tag, ".waddr"}, o_mem_write_addr, e_wa);
      chk16({tag, ".wdata"}, o_mem_write_data, e_wd);
    end
    chk1({tag, ".rvalid"}, o_host_rvalid, m_rvalid);
    if (m_rvalid) chk16({tag, ".hrdata"}, o_host_rdata, m_rd);
    if (m_rd_known) chk16({tag, ".crdata"}, o_cpu_read_data, m_rd);
    obs_gnt = o_host_gnt;
    obs_ce  = o_cpu_ce;
    if (o_host_gnt)
      $display("%s host %s addr=%h wdata=%h", tag, i_host_we ? "wr" : "rd", i_host_addr, i_host_wdata);
    m_rvalid = e_gnt && !i_host_we;
    m_rd = shadow[e_ra];
    m_rd_known = 1'b1;
    if (e_we) shadow[e_wa] = e_wd;
    case (m_owner)
      M_RUN: begin
        m_run++;
        if (i_host_req && (m_run >= MIN_CPU || skip)) begin
          m_owner = M_LEND;
          m_lent = 0;
        end
      end
      M_LEND: begin
        if (!i_host_req) m_owner = M_RETURN;
        else begin
          m_lent++;
          if (m_lent >= MAX_BURST && !skip) m_owner = M_RETURN;
        end
      end
      default: begin
        m_owner = M_RUN;
        m_run = 0;
      end
    endcase
    @(posedge i_clk);
    #1;
  endtask

  typedef struct {
    logic req, hwe;
    logic [15:0] haddr, hwdata, craddr;
    logic ce, gnt, we;
    logic [15:0] raddr;
    logic rvalid;
    logic [15:0] rdata;
  } vec_t;
  vec_t vt [28];

  initial begin
    int k, w0, a0, found, prob, hk;
    bit pend, prev_gnt;
    int gap_at[$];
    int probs [8];

    // Write burst of 3 then read-back burst of 3, cycle by cycle from reset release
    for (int i = 0; i < 28; i++) begin
      vt[i].req = 1'b0; vt[i].hwe = 1'b0; vt[i].haddr = 16'h0; vt[i].hwdata = 16'h0;
      vt[i].craddr = 16'h0010 + 16'(i);
      vt[i].ce = 1'b1; vt[i].gnt = 1'b0; vt[i].we = 1'b0; vt[i].raddr = vt[i].craddr;
      vt[i].rvalid = 1'b0; vt[i].rdata = 16'h0;
    end
    for (int i = 0; i < 12; i++) begin
      vt[i].req = 1'b1; vt[i].hwe = 1'b1;
      vt[i].haddr = (i < 10) ? 16'h0100 : 16'h0100 + 16'(i - 9);
      vt[i].hwdata = (i < 10) ? 16'hA5A0 : 16'hA5A0 + 16'(i - 9);
    end
    for (int i = 9; i < 12; i++) begin
      vt[i].ce = 1'b0; vt[i].gnt = 1'b1; vt[i].we = 1'b1; vt[i].raddr = vt[i].haddr;
    end
    vt[0].ce = 1'b0;
    vt[12].ce = 1'b0; vt[12].raddr = 16'h0;
    vt[13].ce = 1'b0;
    for (int i = 14; i < 25; i++) begin
      vt[i].req = 1'b1;
      vt[i].haddr = (i < 23) ? 16'h0100 : 16'h0100 + 16'(i - 22);
    end
    for (int i = 22; i < 25; i++) begin
      vt[i].ce = 1'b0; vt[i].gnt = 1'b1; vt[i].raddr = vt[i].haddr;
    end
    vt[25].ce = 1'b0; vt[25].raddr = 16'h0;
    vt[26].ce = 1'b0;
    for (int i = 23; i < 26; i++) begin
      vt[i].rvalid = 1'b1; vt[i].rdata = 16'hA5A0 + 16'(i - 23);
    end

    #2;
    apply_reset();
    for (int i = 0; i < 28; i++) begin
      i_host_req = vt[i].req; i_host_we = vt[i].hwe; i_host_addr = vt[i].haddr;
      i_host_wdata = vt[i].hwdata; i_cpu_read_addr = vt[i].craddr; i_cpu_we = 1'b0;
      #4;
      chk1($sformatf("vec%0d.ce", i), o_cpu_ce, vt[i].ce);
      chk1($sformatf("vec%0d.gnt", i), o_host_gnt, vt[i].gnt);
      chk1($sformatf("vec%0d.we", i), o_mem_we, vt[i].we);
      chk16($sformatf("vec%0d.raddr", i), o_mem_read_addr, vt[i].raddr);
      chk1($sformatf("vec%0d.rvalid", i), o_host_rvalid, vt[i].rvalid);
      if (vt[i].rvalid) chk16($sformatf("vec%0d.rdata", i), o_host_rdata, vt[i].rdata);
      $display("vec%0d req=%b gnt=%b ce=%b raddr=%h", i, vt[i].req, o_host_gnt, o_cpu_ce, o_mem_read_addr);
      @(posedge i_clk);
      #1;
    end
    for (int a = 0; a < 3; a++) shadow[16'h0100 + 16'(a)] = 16'hA5A0 + 16'(a);

    // CPU frozen with a pending write to 0x0040 while the host takes three reads
    i_host_req = 1'b0;
    apply_reset();
    i_host_req = 1'b1; i_host_we = 1'b0; i_host_addr = 16'h0200;
    i_cpu_write_addr = 16'h0040; i_cpu_write_data = 16'hBEEF; i_cpu_we = 1'b0;
    hk = 0; w0 = 0; a0 = 0;
    for (int c = 0; c < 20; c++) begin
      if (c == 9) begin
        i_cpu_we = 1'b1;
        w0 = wr_total;
        a0 = wr_40;
      end
      if (c == 14) chki("wb.frozen_writes", wr_total - w0, 0);
      cycle_check("wb");
      if (i_cpu_we && obs_ce) i_cpu_we = 1'b0;
      if (obs_gnt) hk++;
      i_host_addr = 16'h0200 + 16'(hk);
      i_host_req = (hk < 3);
    end
    chki("wb.total_writes", wr_total - w0, 1);
    chki("wb.writes_0040", wr_40 - a0, 1);
    chk16("wb.ram_0040", ram[16'h0040], 16'hBEEF);

    // Reset asserted in the middle of a host read burst
    apply_reset();
    i_host_req = 1'b1; i_host_we = 1'b0; i_host_addr = 16'h0300;
    found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      cycle_check("mid");
      if (obs_gnt) i_host_addr = i_host_addr + 16'h1;
      if (m_owner == M_LEND && m_rvalid) found = 1;
    end
    chki("mid.reached_burst", found, 1);
    #2;
    chk1("mid.gnt_before", o_host_gnt, 1'b1);
    chk1("mid.rvalid_before", o_host_rvalid, 1'b1);
    apply_reset();
    for (int c = 0; c < 12; c++) begin
      cycle_check("mid_after");
      if (obs_gnt) i_host_addr = i_host_addr + 16'h1;
    end

    // 40-word host load with the CPU halted
    i_host_req = 1'b0;
    apply_reset();
    i_cpu_halted = 1'b1;
    k = 0; prev_gnt = 1'b0;
    for (int c = 0; c < 200 && k < 40; c++) begin
      i_host_req = 1'b1; i_host_we = 1'b1;
      i_host_addr = 16'h0400 + 16'(k); i_host_wdata = 16'h1000 + 16'(k);
      cycle_check("load");
      if (obs_gnt) k++;
      else if (k > 0 && prev_gnt) gap_at.push_back(k);
      prev_gnt = obs_gnt;
    end
    chki("load.words", k, 40);
`ifdef MEM_ARB_HALT_BYPASS_EN
    chki("load.gaps", gap_at.size(), 0);
`else
    chki("load.gaps", gap_at.size(), 2);
    chki("load.gap1_after", (gap_at.size() > 0) ? gap_at[0] : -1, 16);
    chki("load.gap2_after", (gap_at.size() > 1) ? gap_at[1] : -1, 32);
`endif
    i_host_req = 1'b0;
    i_cpu_halted = 1'b0;
    cycle_check("load_end");

    // Randomized traffic in segments of different host load
    probs = '{0, 30, 90, 100, 50, 10, 100, 60};
    pend = 1'b0;
    for (int seg = 0; seg < 8; seg++) begin
      prob = probs[seg];
      i_cpu_halted = seg[0];
      for (int c = 0; c < 180; c++) begin
        if (!pend && ($urandom_range(99) < prob)) begin
          pend = 1'b1;
          i_host_we = 1'($urandom_range(1));
          i_host_addr = 16'h0300 + 16'($urandom_range(15));
          i_host_wdata = 16'($urandom);
        end
        i_host_req = pend;
        i_cpu_read_addr = 16'h0300 + 16'($urandom_range(15));
        i_cpu_write_addr = 16'h0300 + 16'($urandom_range(15));
        i_cpu_write_data = 16'($urandom);
        i_cpu_we = ($urandom_range(3) == 0);
        cycle_check($sformatf("rnd%0d", seg));
        if (obs_gnt) pend = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
